// File: rtl/egress_arbiter.sv
//==============================================================================
// Module   : egress_arbiter
// Purpose  : Crossbar arbiter between per-ingress requesters and egress ports.
//            Every egress port runs its own round-robin arbiter over the
//            requesters whose tdest names it. A grant is held for a whole
//            frame and ends on the tlast handshake, or when the granted
//            requester abandons the frame by dropping tvalid. The datapath is
//            a combinational mux on the granted index.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            in_tvalid/tdata/tdest/tlast, in_tready  - requester side
//            out_tvalid/tdata/tlast, out_tready      - egress side
//            stat_frames, stat_aborts - per-egress 16-bit counters
//                                       (EGRESS_ARB_STATS_EN only)
// Config   : EGRESS_ARB_STATS_EN - when defined, adds the frame/abort counters
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module egress_arbiter #(
   parameter int NUM_INGRESS = 4,
   parameter int NUM_EGRESS  = 4,
   parameter int DEST_WIDTH  = 2,
   parameter int DATA_WIDTH  = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_INGRESS-1:0]            in_tvalid,
   input  logic [NUM_INGRESS*DATA_WIDTH-1:0] in_tdata,
   input  logic [NUM_INGRESS*DEST_WIDTH-1:0] in_tdest,
   input  logic [NUM_INGRESS-1:0]            in_tlast,
   output logic [NUM_INGRESS-1:0]            in_tready,
   output logic [NUM_EGRESS-1:0]             out_tvalid,
   output logic [NUM_EGRESS*DATA_WIDTH-1:0]  out_tdata,
   output logic [NUM_EGRESS-1:0]             out_tlast,
   input  logic [NUM_EGRESS-1:0]             out_tready
`ifdef EGRESS_ARB_STATS_EN
   ,
   output logic [NUM_EGRESS*16-1:0]          stat_frames,
   output logic [NUM_EGRESS*16-1:0]          stat_aborts
`endif
);

   localparam int c_idx_w = (NUM_INGRESS > 1) ? $clog2(NUM_INGRESS) : 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t              r_state [NUM_EGRESS];
   logic [c_idx_w-1:0]  r_gnt   [NUM_EGRESS];
   logic [c_idx_w-1:0]  r_rr    [NUM_EGRESS];

   logic [NUM_INGRESS-1:0] w_held;             // requesters owned by some egress
   logic [NUM_EGRESS-1:0]  w_active;           // egress in GRANT and not in reset
   logic [NUM_EGRESS-1:0]  w_found;            // IDLE egress has a pickable request
   logic [c_idx_w-1:0]     w_pick  [NUM_EGRESS];

`ifdef EGRESS_ARB_STATS_EN
   logic [15:0]            r_frames [NUM_EGRESS];
   logic [15:0]            r_aborts [NUM_EGRESS];
`endif

   // First requester set in req at or after ptr, wrapping around.
   function automatic logic [c_idx_w-1:0] f_rr_pick(
      input logic [NUM_INGRESS-1:0] req,
      input logic [c_idx_w-1:0]     ptr
   );
      logic found;
      int   j;
      f_rr_pick = ptr;
      found     = 1'b0;
      for (int k = 0; k < NUM_INGRESS; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_INGRESS) j = j - NUM_INGRESS;
         if (!found && req[j]) begin
            found     = 1'b1;
            f_rr_pick = c_idx_w'(j);
         end
      end
   endfunction

   function automatic logic [c_idx_w-1:0] f_next_ptr(input logic [c_idx_w-1:0] gnt);
      if (gnt == c_idx_w'(NUM_INGRESS - 1)) f_next_ptr = '0;
      else                                  f_next_ptr = gnt + 1'b1;
   endfunction

   always_comb begin
      w_held = '0;
      for (int e = 0; e < NUM_EGRESS; e++) begin
         if (r_state[e] == ST_GRANT) w_held[r_gnt[e]] = 1'b1;
      end
   end

   // Request masking: a requester already held by any egress cannot be
   // picked again (covers a tdest change while granted), and if two IDLE
   // egresses would pick the same requester, the lower egress index wins.
   always_comb begin
      logic [NUM_INGRESS-1:0] v_taken;
      logic [NUM_INGRESS-1:0] v_req;
      v_taken = w_held;
      w_found = '0;
      for (int e = 0; e < NUM_EGRESS; e++) begin
         v_req = '0;
         for (int i = 0; i < NUM_INGRESS; i++) begin
            v_req[i] = in_tvalid[i] && !v_taken[i] &&
                       (in_tdest[i*DEST_WIDTH +: DEST_WIDTH] == DEST_WIDTH'(e));
         end
         w_found[e] = |v_req;
         w_pick[e]  = f_rr_pick(v_req, r_rr[e]);
         if (w_found[e] && (r_state[e] == ST_IDLE)) v_taken[w_pick[e]] = 1'b1;
      end
   end

   // Datapath mux; reset blanks the outputs in the same cycle it is asserted.
   always_comb begin
      out_tvalid = '0;
      out_tlast  = '0;
      out_tdata  = '0;
      in_tready  = '0;
      w_active   = '0;
      for (int e = 0; e < NUM_EGRESS; e++) begin
         w_active[e] = (r_state[e] == ST_GRANT) && !reset;
         if (w_active[e]) begin
            out_tvalid[e] = in_tvalid[r_gnt[e]];
            out_tlast[e]  = in_tlast[r_gnt[e]];
            out_tdata[e*DATA_WIDTH +: DATA_WIDTH] =
               in_tdata[int'(r_gnt[e])*DATA_WIDTH +: DATA_WIDTH];
            in_tready[r_gnt[e]] = out_tready[e];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int e = 0; e < NUM_EGRESS; e++) begin
            r_state[e]  <= ST_IDLE;
            r_gnt[e]    <= '0;
            r_rr[e]     <= '0;
`ifdef EGRESS_ARB_STATS_EN
            r_frames[e] <= '0;
            r_aborts[e] <= '0;
`endif
         end
      end else begin
         for (int e = 0; e < NUM_EGRESS; e++) begin
            case (r_state[e])
               ST_IDLE: begin
                  if (w_found[e]) begin
                     r_gnt[e]   <= w_pick[e];
                     r_state[e] <= ST_GRANT;
                  end
               end
               ST_GRANT: begin
                  if (out_tvalid[e] && out_tready[e] && out_tlast[e]) begin
                     r_state[e]  <= ST_IDLE;
                     r_rr[e]     <= f_next_ptr(r_gnt[e]);
`ifdef EGRESS_ARB_STATS_EN
                     r_frames[e] <= r_frames[e] + 16'd1;
`endif
                  end else if (!in_tvalid[r_gnt[e]]) begin
                     // Requester gave up on the frame (timeout upstream).
                     r_state[e]  <= ST_IDLE;
                     r_rr[e]     <= f_next_ptr(r_gnt[e]);
`ifdef EGRESS_ARB_STATS_EN
                     r_aborts[e] <= r_aborts[e] + 16'd1;
`endif
                  end
               end
               default: r_state[e] <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef EGRESS_ARB_STATS_EN
   always_comb begin
      stat_frames = '0;
      stat_aborts = '0;
      for (int e = 0; e < NUM_EGRESS; e++) begin
         stat_frames[e*16 +: 16] = r_frames[e];
         stat_aborts[e*16 +: 16] = r_aborts[e];
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_egress_arbiter.sv
//==============================================================================
// Module   : tb_egress_arbiter
// Purpose  : Self-checking bench for egress_arbiter. A frame-level model of
//            the arbitration rules predicts every output each cycle; directed
//            phases add literal expectations on beat order and grant order.
// Config   : EGRESS_ARB_STATS_EN - also checks the frame/abort counters
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_egress_arbiter;

   localparam int NI  = 4;
   localparam int NE  = 4;
   localparam int DW  = 2;
   localparam int DAW = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [NI-1:0]     in_tvalid, in_tlast, in_tready, in_tready2;
   logic [NI*DAW-1:0] in_tdata;
   logic [NI*DW-1:0]  in_tdest;
   logic [NE-1:0]     out_tvalid, out_tlast, out_tready;
   logic [NE*DAW-1:0] out_tdata;
   logic [2:0]        out2_tvalid, out2_tlast;
   logic [3*DAW-1:0]  out2_tdata;
`ifdef EGRESS_ARB_STATS_EN
   logic [NE*16-1:0]  stat_frames, stat_aborts;
   logic [3*16-1:0]   stat2_frames, stat2_aborts;
`endif

   egress_arbiter #(.NUM_INGRESS(NI), .NUM_EGRESS(NE), .DEST_WIDTH(DW), .DATA_WIDTH(DAW)) dut (
      .clk(clk), .reset(reset),
      .in_tvalid(in_tvalid), .in_tdata(in_tdata), .in_tdest(in_tdest), .in_tlast(in_tlast),
      .in_tready(in_tready),
      .out_tvalid(out_tvalid), .out_tdata(out_tdata), .out_tlast(out_tlast),
      .out_tready(out_tready)
`ifdef EGRESS_ARB_STATS_EN
      , .stat_frames(stat_frames), .stat_aborts(stat_aborts)
`endif
   );

   // Three-egress instance sharing the same requesters: tdest=3 is out of range here.
   egress_arbiter #(.NUM_INGRESS(NI), .NUM_EGRESS(3), .DEST_WIDTH(DW), .DATA_WIDTH(DAW)) dut2 (
      .clk(clk), .reset(reset),
      .in_tvalid(in_tvalid), .in_tdata(in_tdata), .in_tdest(in_tdest), .in_tlast(in_tlast),
      .in_tready(in_tready2),
      .out_tvalid(out2_tvalid), .out_tdata(out2_tdata), .out_tlast(out2_tlast),
      .out_tready(out_tready[2:0])
`ifdef EGRESS_ARB_STATS_EN
      , .stat_frames(stat2_frames), .stat_aborts(stat2_aborts)
`endif
   );

   int errors = 0;
   int checks = 0;
   logic chk_en = 1'b0;

   // Requester sources: s_frames frames of s_len beats each toward s_dest.
   int         s_len [NI];
   int         s_frames [NI];
   int         s_beat [NI];
   int         s_fid [NI];
   int         s_abort [NI];   // beat index at which the frame is abandoned, -1 = never
   logic [1:0] s_dest [NI];
   logic [NE-1:0] otr = '1;
   logic [NI-1:0] hs = '0;

   // Frame-level model
   logic        m_busy [NE];
   int          m_gnt [NE];
   int          m_rr [NE];
   logic [15:0] m_frames [NE];
   logic [15:0] m_aborts [NE];

   logic [15:0] log_q [NE][$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NI; i++) begin
         logic v;
         v = (s_frames[i] > 0);
         in_tvalid[i]           = v;
         in_tlast[i]            = v && (s_beat[i] == s_len[i] - 1);
         in_tdest[i*DW +: DW]   = s_dest[i];
         in_tdata[i*DAW +: DAW] = {4'(i), 4'(s_fid[i]), 8'(s_beat[i])};
      end
      out_tready = otr;
   endtask

   task automatic advance();
      for (int i = 0; i < NI; i++) begin
         if (hs[i]) begin
            if (in_tlast[i]) begin
               s_beat[i] = 0;
               s_fid[i]++;
               s_frames[i]--;
            end else begin
               s_beat[i]++;
               if (s_abort[i] == s_beat[i]) begin
                  s_frames[i] = 0;
                  s_beat[i]   = 0;
                  s_abort[i]  = -1;
               end
            end
         end
      end
   endtask

   // One clock: inputs change 1 ns after the edge, step returns at the falling edge.
   task automatic step(input logic rv = 1'b0);
      @(posedge clk);
      #1;
      reset = rv;
      advance();
      drive();
      @(negedge clk);
      hs = in_tvalid & in_tready;
   endtask

   function automatic logic srcs_busy();
      srcs_busy = 1'b0;
      for (int i = 0; i < NI; i++) if (s_frames[i] > 0) srcs_busy = 1'b1;
   endfunction

   function automatic logic model_busy();
      model_busy = 1'b0;
      for (int e = 0; e < NE; e++) if (m_busy[e]) model_busy = 1'b1;
   endfunction

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((srcs_busy() || model_busy()) && n < budget) begin
         step();
         n++;
      end
      chk({name, " completes within budget"}, 32'(n < budget), 32'd1);
      step();
   endtask

   task automatic src(input int i, input logic [1:0] dest, input int len, input int frames,
                      input int abort_at);
      s_dest[i]   = dest;
      s_len[i]    = len;
      s_frames[i] = frames;
      s_beat[i]   = 0;
      s_abort[i]  = abort_at;
   endtask

   // Model update at each rising edge from the values present during the cycle.
   task automatic model_update();
      logic [NI-1:0] held;
      int g, idx;
      logic picked;
      if (reset) begin
         for (int e = 0; e < NE; e++) begin
            m_busy[e] = 1'b0; m_gnt[e] = 0; m_rr[e] = 0;
            m_frames[e] = '0; m_aborts[e] = '0;
         end
      end else begin
         held = '0;
         for (int e = 0; e < NE; e++) if (m_busy[e]) held[m_gnt[e]] = 1'b1;
         for (int e = 0; e < NE; e++) begin
            if (m_busy[e]) begin
               g = m_gnt[e];
               if (in_tvalid[g] && out_tready[e] && in_tlast[g]) begin
                  m_busy[e] = 1'b0; m_rr[e] = (g + 1) % NI; m_frames[e] = m_frames[e] + 16'd1;
               end else if (!in_tvalid[g]) begin
                  m_busy[e] = 1'b0; m_rr[e] = (g + 1) % NI; m_aborts[e] = m_aborts[e] + 16'd1;
               end
            end else begin
               picked = 1'b0;
               for (int k = 0; k < NI; k++) begin
                  idx = (m_rr[e] + k) % NI;
                  if (!picked && in_tvalid[idx] && !held[idx] && (int'(in_tdest[idx*DW +: DW]) == e)) begin
                     picked = 1'b1; held[idx] = 1'b1; m_busy[e] = 1'b1; m_gnt[e] = idx;
                  end
               end
            end
         end
      end
   endtask

   task automatic compare();
      logic [NI-1:0] etr;
      logic act;
      int g;
      etr = '0;
      for (int e = 0; e < NE; e++) begin
         g   = m_gnt[e];
         act = m_busy[e] && !reset;
         chk($sformatf("out_tvalid[%0d]", e), 32'(out_tvalid[e]), 32'(act && in_tvalid[g]));
         chk($sformatf("out_tlast[%0d]", e), 32'(out_tlast[e]), 32'(act && in_tlast[g]));
         if (act && in_tvalid[g])
            chk($sformatf("out_tdata[%0d]", e), 32'(out_tdata[e*DAW +: DAW]), 32'(in_tdata[g*DAW +: DAW]));
         if (act && out_tready[e]) etr[g] = 1'b1;
`ifdef EGRESS_ARB_STATS_EN
         chk($sformatf("stat_frames[%0d]", e), 32'(stat_frames[e*16 +: 16]), 32'(m_frames[e]));
         chk($sformatf("stat_aborts[%0d]", e), 32'(stat_aborts[e*16 +: 16]), 32'(m_aborts[e]));
`endif
      end
      chk("in_tready", 32'(in_tready), 32'(etr));
      for (int e = 0; e < NE; e++)
         if (out_tvalid[e] && out_tready[e]) log_q[e].push_back(out_tdata[e*DAW +: DAW]);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_update();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) compare();
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int starts[$];
      int exp_order[4];
      logic [15:0] exp_data[4];
      int k;

      for (int i = 0; i < NI; i++) begin
         src(i, 2'd0, 1, 0, -1);
         s_fid[i] = 0;
      end
      drive();
      step(1'b1);
      step(1'b1);
      chk("reset out_tvalid", 32'(out_tvalid), 32'd0);
      chk("reset out_tlast", 32'(out_tlast), 32'd0);
      chk("reset in_tready", 32'(in_tready), 32'd0);
      chk_en = 1'b1;

      // Single frame: requester 0 -> egress 2, 3 beats
      for (int e = 0; e < NE; e++) log_q[e].delete();
      src(0, 2'd2, 3, 1, -1);
      step();
      chk("p1 grant latency out_tvalid[2]", 32'(out_tvalid[2]), 32'd0);
      step();
      chk("p1 granted out_tvalid[2]", 32'(out_tvalid[2]), 32'd1);
      chk("p1 granted in_tready[0]", 32'(in_tready[0]), 32'd1);
      drain("p1", 40);
      chk("p1 beat count", 32'(log_q[2].size()), 32'd3);
      exp_data = '{16'h0000, 16'h0001, 16'h0002, 16'h0000};
      for (int b = 0; b < 3; b++)
         if (b < log_q[2].size()) chk($sformatf("p1 beat %0d", b), 32'(log_q[2][b]), 32'(exp_data[b]));
      chk("p1 idle after frame", 32'(out_tvalid), 32'd0);
      chk("p1 model rr_ptr_2", 32'(m_rr[2]), 32'd1);

      // Contention on egress 1: requesters 0, 1, 3
      log_q[1].delete();
      src(0, 2'd1, 2, 2, -1);
      src(1, 2'd1, 2, 1, -1);
      src(3, 2'd1, 2, 1, -1);
      drain("p2", 80);
      chk("p2 beat count", 32'(log_q[1].size()), 32'd8);
      foreach (log_q[1][q]) if (log_q[1][q][7:0] == 8'd0) starts.push_back(int'(log_q[1][q][15:12]));
      chk("p2 frame count", 32'(starts.size()), 32'd4);
      exp_order = '{0, 1, 3, 0};
      for (int f = 0; f < 4; f++)
         if (f < starts.size()) chk($sformatf("p2 grant order %0d", f), 32'(starts[f]), 32'(exp_order[f]));

      // Backpressure on egress 0: requester 2, out_tready[0] toggling
      log_q[0].delete();
      src(2, 2'd0, 4, 1, -1);
      k = 0;
      while ((srcs_busy() || model_busy()) && k < 60) begin
         otr[0] = (k % 2 == 0);
         step();
         k++;
      end
      chk("p3 completes within budget", 32'(k < 60), 32'd1);
      otr = '1;
      step();
      chk("p3 beat count", 32'(log_q[0].size()), 32'd4);
      exp_data = '{16'h2000, 16'h2001, 16'h2002, 16'h2003};
      for (int b = 0; b < 4; b++)
         if (b < log_q[0].size()) chk($sformatf("p3 beat %0d", b), 32'(log_q[0][b]), 32'(exp_data[b]));

      // Parallel egresses 0 and 3
      src(0, 2'd0, 2, 1, -1);
      src(1, 2'd3, 2, 1, -1);
      step();
      chk("p4 latency out_tvalid", 32'(out_tvalid), 32'd0);
      step();
      chk("p4 out_tvalid[0]", 32'(out_tvalid[0]), 32'd1);
      chk("p4 out_tvalid[3]", 32'(out_tvalid[3]), 32'd1);
      drain("p4", 40);

      // Abandonment on egress 3: requester 2 drops after 2 beats, requester 1 waits
      log_q[3].delete();
      src(2, 2'd3, 5, 1, 2);
      src(1, 2'd3, 2, 1, -1);
      drain("p5", 60);
      chk("p5 beat count", 32'(log_q[3].size()), 32'd4);
      exp_data = '{16'h2100, 16'h2101, 16'h1200, 16'h1201};
      for (int b = 0; b < 4; b++)
         if (b < log_q[3].size()) chk($sformatf("p5 beat %0d", b), 32'(log_q[3][b]), 32'(exp_data[b]));
      chk("p5 model aborts[3]", 32'(m_aborts[3]), 32'd1);
`ifdef EGRESS_ARB_STATS_EN
      chk("p5 stat_aborts[3]", 32'(stat_aborts[3*16 +: 16]), 32'd1);
      chk("p5 stat_frames[3]", 32'(stat_frames[3*16 +: 16]), 32'd2);
`endif

      // Reset in the middle of a frame
      src(0, 2'd2, 6, 1, -1);
      for (int c = 0; c < 4; c++) step();
      chk("p6 granted before reset", 32'(out_tvalid[2]), 32'd1);
      step(1'b1);
      chk("p6 reset out_tvalid", 32'(out_tvalid), 32'd0);
      chk("p6 reset out_tlast", 32'(out_tlast), 32'd0);
      chk("p6 reset in_tready", 32'(in_tready), 32'd0);
      step();
      chk("p6 idle after reset", 32'(out_tvalid), 32'd0);
      drain("p6", 40);
`ifdef EGRESS_ARB_STATS_EN
      chk("p6 stat_frames[2]", 32'(stat_frames[2*16 +: 16]), 32'd1);
      chk("p6 stat_aborts[3]", 32'(stat_aborts[3*16 +: 16]), 32'd0);
`endif

      // tdest=3 on the three-egress instance is never readied
      src(3, 2'd3, 2, 1, -1);
      for (int c = 0; c < 6; c++) begin
         step();
         chk($sformatf("p7 dut2 in_tready[3] cycle %0d", c), 32'(in_tready2[3]), 32'd0);
         chk($sformatf("p7 dut2 out_tvalid cycle %0d", c), 32'(out2_tvalid), 32'd0);
      end
      drain("p7", 40);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
